hazard_ctrl_unit: RTL and testbench

Parametrised successor to the 5-stage pipeline's hazard logic. Generates forwarding selects, load-use bubbles of configurable length, branch-redirect flushes, and whole-pipe freezes for a data memory with variable latency and a valid/ready handshake. It also runs a memory-wait watchdog. Sits beside the pipeline registers in riscv_pipeline_top and drives all stall/flush enables.

---
 rtl/hazard_ctrl_unit_pkg.sv | 23 ++
 rtl/hazard_ctrl_unit_if.sv | 54 +++++
 rtl/hazard_ctrl_unit_fwd_select.sv | 24 ++
 rtl/hazard_ctrl_unit.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and watchdog FSM states.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        TIMEOUT  = 2'b10
    } hz_state_e;

    // Wide enough for LOAD_USE_STALL-1 with LOAD_USE_STALL up to 3.
    localparam int unsigned LU_CNT_W = 2;

    function automatic int unsigned wait_cnt_width(int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave the controller.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_memread;
    logic                  ex_branch_taken;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  mem_regwrite;
    logic                  wb_regwrite;
    logic                  mem_req;
    logic                  mem_ready;

    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic                  flush_w;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      perf_stall_cnt;
    logic [CNT_W-1:0]      perf_flush_cnt;
    logic [CNT_W-1:0]      perf_memwait_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_memread, ex_branch_taken,
        output mem_rd_addr, wb_rd_addr, mem_regwrite, wb_regwrite, mem_req, mem_ready,
        input  forward_a, forward_b, stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w, mem_timeout,
        input  perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_memread, ex_branch_taken,
        input  mem_rd_addr, wb_rd_addr, mem_regwrite, wb_regwrite, mem_req, mem_ready,
        output forward_a, forward_b, stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w, mem_timeout,
        output perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Forwarding comparator for one EX source operand; MEM result beats WB result, x0 never forwards.
module hazard_ctrl_unit_fwd_select
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs_addr,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_regwrite,
    output fwd_sel_e              sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs_addr)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs_addr)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, load-use bubbles, branch flushes, memory freeze/watchdog.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned MAX_MEM_WAIT   = 15,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave hz
);

    localparam int unsigned           WAIT_W    = wait_cnt_width(MAX_MEM_WAIT);
    localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(MAX_MEM_WAIT);
    localparam logic [LU_CNT_W-1:0]   LU_RELOAD = LU_CNT_W'(LOAD_USE_STALL - 1);

    hz_state_e             state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;

    logic     mstall;
    logic     branch;
    logic     lu;
    logic     lu_active;
    fwd_sel_e fwd_a, fwd_b;
    logic     stall_f, stall_d, stall_e, stall_m;
    logic     flush_d, flush_e, flush_w;

    hazard_ctrl_unit_fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_rs_addr   (hz.ex_rs1_addr),
        .mem_rd_addr  (hz.mem_rd_addr),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd_addr   (hz.wb_rd_addr),
        .wb_regwrite  (hz.wb_regwrite),
        .sel          (fwd_a)
    );

    hazard_ctrl_unit_fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_rs_addr   (hz.ex_rs2_addr),
        .mem_rd_addr  (hz.mem_rd_addr),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd_addr   (hz.wb_rd_addr),
        .wb_regwrite  (hz.wb_regwrite),
        .sel          (fwd_b)
    );

    // TIMEOUT keeps the pipe frozen regardless of the memory handshake.
    assign mstall = (hz.mem_req && !hz.mem_ready) || (state_q == TIMEOUT);
    assign branch = hz.ex_branch_taken && !mstall;
    assign lu     = hz.ex_memread && (hz.ex_rd_addr != '0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));
    assign lu_active = (lu || (lu_cnt_q != '0)) && !mstall && !branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            lu_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lu_cnt_q   <= lu_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mstall) begin
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = (MAX_MEM_WAIT <= 1) ? TIMEOUT : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready || !hz.mem_req) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_d == WAIT_MAX) begin
                        state_d = TIMEOUT;
                    end
                end
            end
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = RUN;
        endcase
    end

    // Bubble countdown: first bubble comes from lu itself, the rest from lu_cnt.
    always_comb begin
        lu_cnt_d = '0;
        if (mstall) begin
            lu_cnt_d = lu_cnt_q;
        end else if (branch) begin
            lu_cnt_d = '0;
        end else if (lu_cnt_q != '0) begin
            lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
        end else if (lu) begin
            lu_cnt_d = LU_RELOAD;
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            if (mstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (branch) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu_active) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign hz.forward_a   = rst ? FWD_REG : fwd_a;
    assign hz.forward_b   = rst ? FWD_REG : fwd_b;
    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.stall_e     = stall_e;
    assign hz.stall_m     = stall_m;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.flush_w     = flush_w;
    assign hz.mem_timeout = (state_q == TIMEOUT);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_d && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (mstall && (memwait_cnt_q != '1)) begin
                memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.perf_stall_cnt   = stall_cnt_q;
    assign hz.perf_flush_cnt   = flush_cnt_q;
    assign hz.perf_memwait_cnt = memwait_cnt_q;
`else
    assign hz.perf_stall_cnt   = {CNT_W{1'b0}};
    assign hz.perf_flush_cnt   = {CNT_W{1'b0}};
    assign hz.perf_memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_ctrl_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control bit order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       use1, use2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_mr, br;
        logic [4:0] mem_rd, wb_rd;
        logic       mem_rw, wb_rw;
        logic       req, rdy;
        logic [1:0] fa, fb;
        logic [6:0] ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

    hazard_ctrl_unit #(
        .REG_ADDR_W     (5),
        .LOAD_USE_STALL (2),
        .MAX_MEM_WAIT   (15),
        .CNT_W          (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    function automatic vec_t zero_vec();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.id_rs1_addr     = v.id_rs1;
        hz.id_rs2_addr     = v.id_rs2;
        hz.id_uses_rs1     = v.use1;
        hz.id_uses_rs2     = v.use2;
        hz.ex_rs1_addr     = v.ex_rs1;
        hz.ex_rs2_addr     = v.ex_rs2;
        hz.ex_rd_addr      = v.ex_rd;
        hz.ex_memread      = v.ex_mr;
        hz.ex_branch_taken = v.br;
        hz.mem_rd_addr     = v.mem_rd;
        hz.wb_rd_addr      = v.wb_rd;
        hz.mem_regwrite    = v.mem_rw;
        hz.wb_regwrite     = v.wb_rw;
        hz.mem_req         = v.req;
        hz.mem_ready       = v.rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic pulse_rst();
        step();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic check_counters(input string tag, input int st, input int fl, input int mw);
        check({tag, "_stall_cnt"}, hz.perf_stall_cnt, PERF ? st : 0);
        check({tag, "_flush_cnt"}, hz.perf_flush_cnt, PERF ? fl : 0);
        check({tag, "_memwait_cnt"}, hz.perf_memwait_cnt, PERF ? mw : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        // v0: MEM and WB both write x5 -> MEM wins
        v = zero_vec(); v.mem_rd = 5; v.mem_rw = 1; v.wb_rd = 5; v.wb_rw = 1; v.ex_rs1 = 5;
        v.fa = 2'b10; tbl.push_back(v);
        // v1: same but MEM targets x0 -> WB
        v.mem_rd = 0; v.fa = 2'b01; tbl.push_back(v);
        // v2: split sources
        v = zero_vec(); v.mem_rd = 7; v.mem_rw = 1; v.wb_rd = 9; v.wb_rw = 1;
        v.ex_rs1 = 9; v.ex_rs2 = 7; v.fa = 2'b01; v.fb = 2'b10; tbl.push_back(v);
        // v3: MEM matches but not writing -> WB on rs2
        v = zero_vec(); v.mem_rd = 7; v.wb_rd = 7; v.wb_rw = 1; v.ex_rs1 = 3; v.ex_rs2 = 7;
        v.fb = 2'b01; tbl.push_back(v);
        // v4: x0 never forwarded
        v = zero_vec(); v.mem_rw = 1; v.wb_rw = 1; tbl.push_back(v);
        // v5: load-use on rs2
        v = zero_vec(); v.ex_mr = 1; v.ex_rd = 3; v.id_rs2 = 3; v.use2 = 1; v.ctl = C_LU;
        tbl.push_back(v);
        // v6: rs2 matches but unused
        v.use2 = 0; v.ctl = C_NONE; tbl.push_back(v);
        // v7: load into x0
        v = zero_vec(); v.ex_mr = 1; v.use1 = 1; tbl.push_back(v);
        // v8: match but not a load
        v = zero_vec(); v.ex_rd = 4; v.id_rs1 = 4; v.use1 = 1; tbl.push_back(v);
        // v9: load-use on rs1
        v.ex_mr = 1; v.ctl = C_LU; tbl.push_back(v);
        // v10: load-use plus branch -> branch wins
        v.br = 1; v.ctl = C_BR; tbl.push_back(v);
        // v11: memory stall beats branch and load-use
        v.req = 1; v.ctl = C_MEM; tbl.push_back(v);
        // v12: memory completes -> no freeze, branch applies
        v.rdy = 1; v.ctl = C_BR; tbl.push_back(v);
        // v13: plain memory stall with forwarding active
        v = zero_vec(); v.req = 1; v.mem_rd = 2; v.mem_rw = 1; v.ex_rs2 = 2;
        v.fb = 2'b10; v.ctl = C_MEM; tbl.push_back(v);
        // v14: branch alone
        v = zero_vec(); v.br = 1; v.ctl = C_BR; tbl.push_back(v);

        // Reset state: outputs forced low while rst is high
        v = zero_vec(); v.mem_rd = 5; v.mem_rw = 1; v.ex_rs1 = 5; v.req = 1;
        drive(v);
        #3;
        check("rst_ctl", {25'd0, ctl_now()}, {25'd0, C_NONE});
        check("rst_fwd_a", {30'd0, hz.forward_a}, 32'd0);
        check("rst_timeout", {31'd0, hz.mem_timeout}, 32'd0);
        check_counters("rst", 0, 0, 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            pulse_rst();
            drive(tbl[i]);
            settle();
            check($sformatf("vec%0d_fwd_a", i), {30'd0, hz.forward_a}, {30'd0, tbl[i].fa});
            check($sformatf("vec%0d_fwd_b", i), {30'd0, hz.forward_b}, {30'd0, tbl[i].fb});
            check($sformatf("vec%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, tbl[i].ctl});
        end

        // Load-use with LOAD_USE_STALL=2: exactly two bubble cycles
        pulse_rst();
        v = zero_vec(); v.ex_mr = 1; v.ex_rd = 3; v.id_rs2 = 3; v.use2 = 1;
        drive(v); settle();
        check("lu_c1", {25'd0, ctl_now()}, {25'd0, C_LU});
        step(); drive(zero_vec()); settle();
        check("lu_c2", {25'd0, ctl_now()}, {25'd0, C_LU});
        step(); settle();
        check("lu_c3", {25'd0, ctl_now()}, {25'd0, C_NONE});
        check_counters("lu", 2, 0, 0);

        // Load-use and branch together: flush only, no trailing bubble
        pulse_rst();
        v.br = 1;
        drive(v); settle();
        check("lubr_c1", {25'd0, ctl_now()}, {25'd0, C_BR});
        step(); drive(zero_vec()); settle();
        check("lubr_c2", {25'd0, ctl_now()}, {25'd0, C_NONE});
        step(); settle();
        check_counters("lubr", 0, 1, 0);

        // Four-cycle memory wait with a branch pending; branch flushes on release
        pulse_rst();
        v = zero_vec(); v.req = 1; v.br = 1;
        drive(v);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("mw_c%0d", i), {25'd0, ctl_now()}, {25'd0, C_MEM});
            step();
        end
        v.rdy = 1; drive(v); settle();
        check("mw_release", {25'd0, ctl_now()}, {25'd0, C_BR});
        step(); drive(zero_vec()); settle();
        check("mw_after", {25'd0, ctl_now()}, {25'd0, C_NONE});
        check_counters("mw", 4, 1, 4);
        // A second wait just below the limit must not trip the watchdog
        v = zero_vec(); v.req = 1;
        drive(v);
        for (int i = 0; i < 14; i++) step();
        v.rdy = 1; drive(v); settle();
        check("mw2_timeout", {31'd0, hz.mem_timeout}, 32'd0);
        check("mw2_ctl", {25'd0, ctl_now()}, {25'd0, C_NONE});
        step(); drive(zero_vec());

        // Watchdog: 15 not-ready cycles -> sticky timeout
        pulse_rst();
        v = zero_vec(); v.req = 1;
        drive(v);
        for (int i = 0; i < 14; i++) step();
        settle();
        check("to_pre", {31'd0, hz.mem_timeout}, 32'd0);
        step(); settle();
        check("to_set", {31'd0, hz.mem_timeout}, 32'd1);
        v.rdy = 1; v.mem_rd = 5; v.mem_rw = 1; v.ex_rs1 = 5;
        drive(v); settle();
        check("to_hold_ctl", {25'd0, ctl_now()}, {25'd0, C_MEM});
        check("to_hold_fwd", {30'd0, hz.forward_a}, 32'd2);
        step(); step(); settle();
        check("to_sticky", {31'd0, hz.mem_timeout}, 32'd1);
        check_counters("to", 17, 0, 17);
        // Asynchronous reset between clock edges
        rst = 1'b1;
        #1;
        check("arst_ctl", {25'd0, ctl_now()}, {25'd0, C_NONE});
        check("arst_fwd", {30'd0, hz.forward_a}, 32'd0);
        check("arst_timeout", {31'd0, hz.mem_timeout}, 32'd0);
        check_counters("arst", 0, 0, 0);
        rst = 1'b0;
        #1;
        check("arst_rel_fwd", {30'd0, hz.forward_a}, 32'd2);
        check("arst_rel_ctl", {25'd0, ctl_now()}, {25'd0, C_NONE});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
